// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read front-end presenting a valid/ready stream with fill threshold
// Optional rd_cnt_o handshake counter: define FIFO_STREAM_READER_CNT_EN.
module fifo_stream_reader #(
  parameter int SHOW_AHEAD  = 1,
  parameter int D_WIDTH     = 24,
  parameter int USEDW_WIDTH = 8,
  parameter int START_LEVEL = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [D_WIDTH-1:0]     data_i,
  input  logic                   empty_i,
  input  logic                   full_i,
  input  logic [USEDW_WIDTH-1:0] usedw_i,
  output logic                   rdreq_o,
  output logic [D_WIDTH-1:0]     data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy_o
`ifdef FIFO_STREAM_READER_CNT_EN
  ,
  output logic [31:0]            rd_cnt_o
`endif
);

  localparam int          BUF_DEPTH = (SHOW_AHEAD != 0) ? 2 : 3;
  localparam logic [2:0]  BUF_LIMIT = 3'(BUF_DEPTH);
  localparam logic [31:0] LEVEL     = 32'(START_LEVEL);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t             state_q;
  logic [1:0]         cnt_q;
  logic               inflight_q;
  logic [D_WIDTH-1:0] mem_q [0:2];
  logic [D_WIDTH-1:0] mem_d [0:2];
  logic [2:0]         outstanding;
  logic [1:0]         wr_idx;
  logic               level_ok;
  logic               pop;
  logic               push;
  logic               underrun;

  // Reads are gated by reset so no FIFO word is consumed while it would be discarded.
  assign outstanding = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign rdreq_o     = ~rst_i & en_i & (state_q == STREAM) & ~empty_i & (outstanding < BUF_LIMIT);

  if (START_LEVEL == 0) begin : g_no_level
    logic unused_level;
    assign unused_level = ^{usedw_i, full_i};
    assign level_ok     = 1'b1;
  end else begin : g_level
    assign level_ok = (32'(usedw_i) >= LEVEL) | full_i;
  end

  assign valid_o  = (cnt_q != 2'd0);
  assign data_o   = mem_q[0];
  assign busy_o   = (state_q != IDLE) | (cnt_q != 2'd0) | inflight_q;
  assign pop      = valid_o & ready_i;
  assign push     = (SHOW_AHEAD != 0) ? rdreq_o : inflight_q;
  assign wr_idx   = pop ? (cnt_q - 2'd1) : cnt_q;
  assign underrun = (START_LEVEL != 0) & empty_i & (cnt_q == 2'd0) & ~inflight_q;

  // Head stays put when the last word pops, so data_o holds its final value.
  always_comb begin
    mem_d = mem_q;
    if (pop && (cnt_q > 2'd1)) begin
      mem_d[0] = mem_q[1];
      mem_d[1] = mem_q[2];
    end
    if (push) begin
      mem_d[wr_idx] = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      case (state_q)
        IDLE:    if (en_i) state_q <= FILL;
        FILL: begin
          if (!en_i)         state_q <= IDLE;
          else if (level_ok) state_q <= STREAM;
        end
        STREAM: begin
          if (!en_i)         state_q <= IDLE;
          else if (underrun) state_q <= FILL;
        end
        default: state_q <= IDLE;
      endcase
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
      inflight_q <= (SHOW_AHEAD == 0) & rdreq_o;
      mem_q      <= mem_d;
    end
  end

`ifdef FIFO_STREAM_READER_CNT_EN
  logic [31:0] rd_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)    rd_cnt_q <= 32'd0;
    else if (pop) rd_cnt_q <= rd_cnt_q + 32'd1;
  end

  assign rd_cnt_o = rd_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - randomized scoreboard bench for fifo_stream_reader (three configurations)
module tb_fifo_stream_reader;

  localparam int DW     = 24;
  localparam int FDEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, ready;
  logic          empty [3];
  logic          full  [3];
  logic [7:0]    usedw [3];
  logic [DW-1:0] din   [3];
  logic          rdreq [3];
  logic          valid [3];
  logic          busy  [3];
  logic [DW-1:0] dout  [3];
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [31:0]   rd_cnt [3];
  logic [31:0]   hs_cnt [3];
`endif

  logic [DW-1:0] fq   [3][$];
  logic [DW-1:0] pend [3][$];
  logic [DW-1:0] rdd  [3];
  logic [DW-1:0] hold [3];
  logic          rd_s [3];
  logic          hs_s [3];
  logic          rst_s, push_s, push_req;
  logic [DW-1:0] pushv_s, push_val, wv;

  int cyc = 0;
  bit stat_on;
  int rd_n [3], rd_first [3], rd_last [3];
  int vd_n [3], vd_first [3], vd_last [3];
  int n_checks = 0;
  int n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  fifo_stream_reader #(.SHOW_AHEAD(1), .D_WIDTH(DW), .USEDW_WIDTH(8), .START_LEVEL(0)) dut_sa (
    .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din[0]), .empty_i(empty[0]), .full_i(full[0]),
    .usedw_i(usedw[0]), .rdreq_o(rdreq[0]), .data_o(dout[0]), .valid_o(valid[0]),
    .ready_i(ready), .busy_o(busy[0])
`ifdef FIFO_STREAM_READER_CNT_EN
    , .rd_cnt_o(rd_cnt[0])
`endif
  );

  fifo_stream_reader #(.SHOW_AHEAD(0), .D_WIDTH(DW), .USEDW_WIDTH(8), .START_LEVEL(0)) dut_reg (
    .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din[1]), .empty_i(empty[1]), .full_i(full[1]),
    .usedw_i(usedw[1]), .rdreq_o(rdreq[1]), .data_o(dout[1]), .valid_o(valid[1]),
    .ready_i(ready), .busy_o(busy[1])
`ifdef FIFO_STREAM_READER_CNT_EN
    , .rd_cnt_o(rd_cnt[1])
`endif
  );

  fifo_stream_reader #(.SHOW_AHEAD(0), .D_WIDTH(DW), .USEDW_WIDTH(8), .START_LEVEL(4)) dut_lvl (
    .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din[2]), .empty_i(empty[2]), .full_i(full[2]),
    .usedw_i(usedw[2]), .rdreq_o(rdreq[2]), .data_o(dout[2]), .valid_o(valid[2]),
    .ready_i(ready), .busy_o(busy[2])
`ifdef FIFO_STREAM_READER_CNT_EN
    , .rd_cnt_o(rd_cnt[2])
`endif
  );

  function automatic int sa_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int bd_of(input int k);
    return (sa_of(k) != 0) ? 2 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 3; k++) begin
      rd_n[k] = 0; rd_first[k] = -1; rd_last[k] = -1;
      vd_n[k] = 0; vd_first[k] = -1; vd_last[k] = -1;
    end
  endtask

  task automatic drive_fifo_outputs();
    for (int k = 0; k < 3; k++) begin
      empty[k] = (fq[k].size() == 0);
      full[k]  = (fq[k].size() == FDEPTH);
      usedw[k] = 8'(fq[k].size());
      if (sa_of(k) != 0) din[k] = (fq[k].size() != 0) ? fq[k][0] : '0;
      else               din[k] = rdd[k];
    end
  endtask

  // Stream rules: every delivered word is the oldest word taken from the FIFO and not yet delivered.
  task automatic sample_and_check();
    for (int k = 0; k < 3; k++) begin
      if (rdreq[k]) check($sformatf("rd_empty%0d", k), 32'(empty[k]), 32'd0);
      if (!en)      check($sformatf("rd_disabled%0d", k), 32'(rdreq[k]), 32'd0);
      check($sformatf("outstanding%0d", k), 32'(pend[k].size() <= bd_of(k)), 32'd1);
      if (valid[k]) begin
        check($sformatf("has_word%0d", k), 32'(pend[k].size() != 0), 32'd1);
        if (pend[k].size() != 0) check($sformatf("data%0d", k), 32'(dout[k]), 32'(pend[k][0]));
      end
      if (pend[k].size() != 0) check($sformatf("busy%0d", k), 32'(busy[k]), 32'd1);
`ifdef FIFO_STREAM_READER_CNT_EN
      check($sformatf("rd_cnt%0d", k), rd_cnt[k], hs_cnt[k]);
`endif
      rd_s[k] = rdreq[k];
      hs_s[k] = valid[k] & ready;
      if (stat_on) begin
        if (rdreq[k]) begin
          if (rd_n[k] == 0) rd_first[k] = cyc;
          rd_last[k] = cyc;
          rd_n[k]++;
        end
        if (valid[k]) begin
          if (vd_n[k] == 0) vd_first[k] = cyc;
          vd_last[k] = cyc;
          vd_n[k]++;
        end
      end
    end
    rst_s   = rst;
    push_s  = push_req;
    pushv_s = push_val;
  endtask

  task automatic model_update();
    logic [DW-1:0] w;
    for (int k = 0; k < 3; k++) begin
      if (rd_s[k] && fq[k].size() != 0) begin
        w = fq[k].pop_front();
        pend[k].push_back(w);
        rdd[k] = w;
      end
      if (hs_s[k] && pend[k].size() != 0) void'(pend[k].pop_front());
      if (rst_s) pend[k].delete();
`ifdef FIFO_STREAM_READER_CNT_EN
      if (rst_s)        hs_cnt[k] = 32'd0;
      else if (hs_s[k]) hs_cnt[k] = hs_cnt[k] + 32'd1;
`endif
      if (push_s && fq[k].size() < FDEPTH) fq[k].push_back(pushv_s);
    end
    drive_fifo_outputs();
  endtask

  task automatic tick();
    @(negedge clk);
    sample_and_check();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic set_push(input bit on);
    push_req = on;
    if (on) begin
      wv       = wv + 1'b1;
      push_val = wv;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_valid%0d", tag, k), 32'(valid[k]), 32'd0);
      check($sformatf("%s_data%0d", tag, k),  32'(dout[k]),  32'd0);
      check($sformatf("%s_rdreq%0d", tag, k), 32'(rdreq[k]), 32'd0);
      check($sformatf("%s_busy%0d", tag, k),  32'(busy[k]),  32'd0);
`ifdef FIFO_STREAM_READER_CNT_EN
      check($sformatf("%s_cnt%0d", tag, k),   rd_cnt[k],     32'd0);
`endif
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ready = 1'b0; push_req = 1'b0; push_val = '0; wv = '0;
    stat_on = 1'b0; rst_s = 1'b0; push_s = 1'b0; pushv_s = '0;
    for (int k = 0; k < 3; k++) begin
      rd_s[k] = 1'b0; hs_s[k] = 1'b0; rdd[k] = '0; hold[k] = '0;
`ifdef FIFO_STREAM_READER_CNT_EN
      hs_cnt[k] = 32'd0;
`endif
    end
    clear_stats();
    drive_fifo_outputs();
    repeat (3) tick();
    rst = 1'b0;
    check_idle_outputs("reset");

    // Preload 1..8, then stream at full rate.
    for (int i = 0; i < 8; i++) begin set_push(1'b1); tick(); end
    set_push(1'b0);
    clear_stats(); stat_on = 1'b1; en = 1'b1; ready = 1'b1;
    repeat (20) tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("burst_rd_n%0d", k),   32'(rd_n[k]), 32'd8);
      check($sformatf("burst_rd_span%0d", k), 32'(rd_last[k] - rd_first[k]), 32'd7);
      check($sformatf("burst_vd_n%0d", k),   32'(vd_n[k]), 32'd8);
      check($sformatf("burst_vd_span%0d", k), 32'(vd_last[k] - vd_first[k]), 32'd7);
      check($sformatf("burst_latency%0d", k), 32'(vd_first[k] - rd_first[k]), (sa_of(k) != 0) ? 32'd1 : 32'd2);
      check($sformatf("burst_drained%0d", k), 32'(pend[k].size()), 32'd0);
    end

    // Backpressure window of 10 cycles while the FIFO keeps filling.
    for (int i = 0; i < 6; i++) begin set_push(1'b1); tick(); end
    ready = 1'b0; clear_stats();
    for (int i = 0; i < 3; i++) begin set_push(1'b1); tick(); end
    for (int k = 0; k < 3; k++) hold[k] = dout[k];
    for (int i = 0; i < 7; i++) begin set_push(1'b1); tick(); end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_reads%0d", k), 32'(rd_n[k] <= bd_of(k)), 32'd1);
      check($sformatf("bp_valid%0d", k), 32'(valid[k]), 32'd1);
      check($sformatf("bp_hold%0d", k),  32'(dout[k]), 32'(hold[k]));
      check($sformatf("bp_rdreq%0d", k), 32'(rdreq[k]), 32'd0);
    end
    set_push(1'b0); ready = 1'b1;
    repeat (30) tick();
    for (int k = 0; k < 3; k++) check($sformatf("bp_drained%0d", k), 32'(pend[k].size() + fq[k].size()), 32'd0);

    // Threshold of 4 on the third instance, including re-prime after underrun.
    for (int i = 0; i < 3; i++) begin set_push(1'b1); tick(); end
    set_push(1'b0); clear_stats(); stat_on = 1'b1;
    repeat (10) tick();
    check("lvl_below_rd", 32'(rd_n[2]), 32'd0);
    check("lvl_below_fifo", 32'(fq[2].size()), 32'd3);
    set_push(1'b1); tick(); set_push(1'b0);
    clear_stats();
    repeat (2) tick();
    check("lvl_start_rd", 32'(rd_n[2]), 32'd1);
    repeat (10) tick();
    check("lvl_delivered", 32'(fq[2].size() + pend[2].size()), 32'd0);
    for (int i = 0; i < 2; i++) begin set_push(1'b1); tick(); end
    set_push(1'b0); clear_stats();
    repeat (10) tick();
    check("reprime_rd", 32'(rd_n[2]), 32'd0);
    check("reprime_fifo", 32'(fq[2].size()), 32'd2);
    for (int i = 0; i < 2; i++) begin set_push(1'b1); tick(); end
    set_push(1'b0);
    repeat (12) tick();
    check("reprime_delivered", 32'(fq[2].size() + pend[2].size()), 32'd0);
    stat_on = 1'b0;

    // Enable dropped with words buffered: reads stop at once, buffer still drains.
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin set_push(1'b1); tick(); end
    set_push(1'b0); en = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("endrop_rdreq%0d", k), 32'(rdreq[k]), 32'd0);
    ready = 1'b1;
    repeat (20) tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("endrop_pend%0d", k),  32'(pend[k].size()), 32'd0);
      check($sformatf("endrop_valid%0d", k), 32'(valid[k]), 32'd0);
      check($sformatf("endrop_busy%0d", k),  32'(busy[k]), 32'd0);
    end

    // Reset pulse mid-stream with full buffers.
    en = 1'b1; ready = 1'b0;
    for (int i = 0; i < 6; i++) begin set_push(1'b1); tick(); end
    set_push(1'b0); rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("midrst");
    ready = 1'b1;
    repeat (20) tick();

    // Random traffic, enable toggles and occasional resets.
    for (int c = 0; c < 2000; c++) begin
      set_push($urandom_range(0, 99) < 55);
      ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 3) en = ~en;
      rst = ($urandom_range(0, 999) < 4);
      tick();
    end
    rst = 1'b0; set_push(1'b0); en = 1'b1; ready = 1'b1;
    repeat (40) tick();
    for (int k = 0; k < 3; k++) check($sformatf("final_pend%0d", k), 32'(pend[k].size()), 32'd0);
    for (int k = 0; k < 2; k++) check($sformatf("final_fifo%0d", k), 32'(fq[k].size()), 32'd0);
    en = 1'b0;
    repeat (5) tick();
    for (int k = 0; k < 3; k++) check($sformatf("final_busy%0d", k), 32'(busy[k]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
